// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, counter width and saturating increment for the Rx frame controller
package uart_rx_pkg;
  typedef enum logic [1:0] {IDLE, EVAL, PUSH, DROP} ctrl_state_t;
  localparam int CNT_W = 16;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with clear, occupancy count and write-through-when-full-and-popping
module uart_rx_fifo #(
  parameter int width = 9,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic                     clr,
  input  logic [width-1:0]         wr_data,
  output logic [width-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   level
);
  localparam int aw = $clog2(depth);
  logic [width-1:0] mem [depth];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign full = level == (aw+1)'(depth);
  assign empty = level == '0;
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_wr) mem[wr_ptr] <= wr_data;
      if (do_wr) wr_ptr <= wr_ptr + aw'(1);
      if (do_rd) rd_ptr <= rd_ptr + aw'(1);
      level <= level + (aw+1)'(do_wr) - (aw+1)'(do_rd);
    end
  end
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: captures, filters and queues UART Rx frames; UART_RX_ERR_CNT_EN adds error/overflow counters
module uart_rx_frame_ctrl import uart_rx_pkg::*; #(
  parameter int data_size   = 8,
  parameter int fifo_depth  = 4,
  parameter bit pass_errors = 1'b0
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          frame_done,
  input  logic                          trans_error,
  input  logic                          data_error,
  input  logic [data_size-1:0]          rx_data,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [data_size-1:0]          out_data,
  output logic                          out_err,
  output logic [$clog2(fifo_depth):0]   fifo_level,
  output logic                          overflow,
  output logic                          drop_pulse
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]              trans_err_cnt,
  output logic [CNT_W-1:0]              data_err_cnt,
  output logic [CNT_W-1:0]              ovf_cnt
`endif
);
  ctrl_state_t state_q, state_d;
  logic fd_q, te_q, de_q, err, new_frame, pop, full, empty, wr_en, set_ovf;
  logic [data_size-1:0] data_q;
  logic [data_size:0] head;
  assign new_frame = frame_done & ~fd_q;
  assign err = te_q | de_q;
  assign pop = out_valid & out_ready;
  assign out_valid = ~empty;
  assign out_data = head[data_size:1];
  assign out_err = pass_errors & head[0];
  uart_rx_fifo #(.width(data_size + 1), .depth(fifo_depth)) u_fifo (
    .clk(sys_clk),
    .rst(rst),
    .wr_en(wr_en),
    .rd_en(pop),
    .clr(flush),
    .wr_data({data_q, err}),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  always_comb begin
    state_d = state_q;
    wr_en = 1'b0;
    set_ovf = 1'b0;
    drop_pulse = 1'b0;
    case (state_q)
      IDLE: state_d = new_frame ? EVAL : IDLE;
      EVAL: begin
        // a pop in this cycle frees a slot before the PUSH cycle writes
        set_ovf = !(err && !pass_errors) && full && !pop;
        state_d = (err && !pass_errors) || set_ovf ? DROP : PUSH;
      end
      PUSH: begin
        wr_en = 1'b1;
        state_d = IDLE;
      end
      default: begin
        drop_pulse = 1'b1;
        state_d = IDLE;
      end
    endcase
    if (flush) state_d = IDLE;
  end
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fd_q <= 1'b0;
      data_q <= '0;
      te_q <= 1'b0;
      de_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      fd_q <= frame_done;
      if (state_q == IDLE && new_frame) {data_q, te_q, de_q} <= {rx_data, trans_error, data_error};
      overflow <= flush ? 1'b0 : overflow | set_ovf;
    end
  end
`ifdef UART_RX_ERR_CNT_EN
  logic eval;
  assign eval = state_q == EVAL;
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      trans_err_cnt <= '0;
      data_err_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      trans_err_cnt <= sat_inc(trans_err_cnt, eval & te_q);
      data_err_cnt <= sat_inc(data_err_cnt, eval & de_q);
      ovf_cnt <= sat_inc(ovf_cnt, set_ovf);
    end
  end
`endif
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed scoreboard bench for uart_rx_frame_ctrl (drop and pass-errors instances)
module tb_uart_rx_frame_ctrl;
  logic clk = 1'b0, rst = 1'b1, fd0 = 1'b0, fd1 = 1'b0, te = 1'b0, de = 1'b0, flush = 1'b0, rdy = 1'b0;
  logic [7:0] rx = '0;
  logic v0, e0, ovf0, drop0, v1, e1, ovf1, drop1;
  logic [7:0] d0, d1;
  logic [2:0] lvl0, lvl1;
`ifdef UART_RX_ERR_CNT_EN
  logic [15:0] tc0, dc0, oc0, tc1, dc1, oc1;
`endif
  int checks = 0, errors = 0, drops = 0, base = 0;
  logic [8:0] sb [$];
  logic [8:0] exp_w;
  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(.data_size(8), .fifo_depth(4), .pass_errors(1'b0)) dut0 (
    .sys_clk(clk), .rst(rst), .frame_done(fd0), .trans_error(te), .data_error(de), .rx_data(rx),
    .flush(flush), .out_valid(v0), .out_ready(rdy), .out_data(d0), .out_err(e0), .fifo_level(lvl0),
    .overflow(ovf0), .drop_pulse(drop0)
`ifdef UART_RX_ERR_CNT_EN
    , .trans_err_cnt(tc0), .data_err_cnt(dc0), .ovf_cnt(oc0)
`endif
  );

  uart_rx_frame_ctrl #(.data_size(8), .fifo_depth(4), .pass_errors(1'b1)) dut1 (
    .sys_clk(clk), .rst(rst), .frame_done(fd1), .trans_error(te), .data_error(de), .rx_data(rx),
    .flush(flush), .out_valid(v1), .out_ready(1'b0), .out_data(d1), .out_err(e1), .fifo_level(lvl1),
    .overflow(ovf1), .drop_pulse(drop1)
`ifdef UART_RX_ERR_CNT_EN
    , .trans_err_cnt(tc1), .data_err_cnt(dc1), .ovf_cnt(oc1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at posedge+1; returns 3 edges after the rising edge was sampled
  task automatic frame(input logic [7:0] d, input logic t, input logic p, input bit which, input bit rdy_eval);
    rx = d; te = t; de = p;
    if (which) fd1 = 1'b1; else fd0 = 1'b1;
    @(posedge clk); #1;
    fd0 = 1'b0; fd1 = 1'b0;
    if (rdy_eval) rdy = 1'b1;
    @(posedge clk); #1;
    if (rdy_eval) rdy = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (drop0) drops++;
    if (!rst && v0 && rdy) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'(1));
      else begin
        exp_w = sb.pop_front();
        chk("head", 32'({e0, d0}), 32'(exp_w));
      end
    end
  end

  initial begin
    #3;
    chk("rst_valid", 32'(v0), 32'(0));
    chk("rst_level", 32'(lvl0), 32'(0));
    chk("rst_ovf", 32'(ovf0), 32'(0));
    chk("rst_drop", 32'(drop0), 32'(0));
    chk("rst_data", 32'(d0), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(1);
    // clean frame, consumer ready
    rdy = 1'b1;
    sb.push_back({1'b0, 8'hA5});
    frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_valid", 32'(v0), 32'(1));
    chk("t1_data", 32'(d0), 32'hA5);
    chk("t1_err", 32'(e0), 32'(0));
    cycles(2);
    chk("t1_drained", 32'(sb.size()), 32'(0));
    chk("t1_level", 32'(lvl0), 32'(0));
    // parity error: dropped without pass_errors, tagged with it
    rdy = 1'b0;
    base = drops;
    frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    cycles(1);
    chk("t2_drop", 32'(drops - base), 32'(1));
    chk("t2_level", 32'(lvl0), 32'(0));
    chk("t2_ovf", 32'(ovf0), 32'(0));
    frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t2p_valid", 32'(v1), 32'(1));
    chk("t2p_data", 32'(d1), 32'h3C);
    chk("t2p_err", 32'(e1), 32'(1));
    chk("t2p_drop", 32'(drop1), 32'(0));
    // five frames into depth 4
    base = drops;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) sb.push_back({1'b0, 8'(i)});
      frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("t3_level", 32'(lvl0), 32'(4));
    chk("t3_ovf", 32'(ovf0), 32'(1));
    chk("t3_drop", 32'(drops - base), 32'(1));
    rdy = 1'b1;
    cycles(6);
    rdy = 1'b0;
    chk("t3_drained", 32'(sb.size()), 32'(0));
    chk("t3_level0", 32'(lvl0), 32'(0));
    // full FIFO with a pop on the EVAL cycle
    for (int i = 0; i < 5; i++) begin
      sb.push_back({1'b0, 8'(8'h11 + i)});
      frame(8'(8'h11 + i), 1'b0, 1'b0, 1'b0, i == 4);
      if (i == 3) begin
        chk("t4_full", 32'(lvl0), 32'(4));
        base = drops;
      end
    end
    chk("t4_nodrop", 32'(drops - base), 32'(0));
    chk("t4_level", 32'(lvl0), 32'(4));
    rdy = 1'b1;
    cycles(6);
    rdy = 1'b0;
    chk("t4_order", 32'(sb.size()), 32'(0));
    // flush with level 3 and sticky overflow
    for (int i = 0; i < 3; i++) frame(8'(8'h21 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_level3", 32'(lvl0), 32'(3));
    chk("t5_ovf1", 32'(ovf0), 32'(1));
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    chk("t5_level", 32'(lvl0), 32'(0));
    chk("t5_ovf", 32'(ovf0), 32'(0));
    chk("t5_valid", 32'(v0), 32'(0));
    // async reset while in EVAL
    frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_pre", 32'(lvl0), 32'(1));
    rx = 8'h99; fd0 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; fd0 = 1'b0;
    #1;
    chk("t6_valid", 32'(v0), 32'(0));
    chk("t6_level", 32'(lvl0), 32'(0));
    chk("t6_data", 32'(d0), 32'(0));
    chk("t6_drop", 32'(drop0), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(1);
    chk("t6_nostale", 32'(v0), 32'(0));
    rdy = 1'b1;
    sb.push_back({1'b0, 8'h77});
    frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_valid77", 32'(v0), 32'(1));
    chk("t6_data77", 32'(d0), 32'h77);
    cycles(3);
    chk("t6_drained", 32'(sb.size()), 32'(0));
`ifdef UART_RX_ERR_CNT_EN
    for (int i = 0; i < 3; i++) frame(8'(8'h40 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("cnt_trans", 32'(tc0), 32'(3));
    chk("cnt_data", 32'(dc0), 32'(0));
    chk("cnt_ovf", 32'(oc0), 32'(0));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
